// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the instruction cache: datapath word size,
// default geometry with derived address-field widths, and FSM states.
package instruction_cache_pkg;

    localparam int WORD_SIZE     = 16;
    localparam int IC_LINE_WORDS = 4;
    localparam int IC_NUM_LINES  = 4;

    localparam int IC_OFFSET_W = $clog2(IC_LINE_WORDS);
    localparam int IC_INDEX_W  = $clog2(IC_NUM_LINES);
    localparam int IC_TAG_W    = WORD_SIZE - IC_OFFSET_W - IC_INDEX_W;

    typedef enum logic {
        IC_IDLE = 1'b0,
        IC_FILL = 1'b1
    } ic_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the
// cache hit/miss performance counters.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, and a
// whole-line fill from instruction memory on a miss while fetch is stalled.
module instruction_cache #(
    parameter int WORD_SIZE  = instruction_cache_pkg::WORD_SIZE,
    parameter int LINE_WORDS = instruction_cache_pkg::IC_LINE_WORDS,
    parameter int NUM_LINES  = instruction_cache_pkg::IC_NUM_LINES
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             i_read,
    input  logic [WORD_SIZE-1:0]             i_address,
    output logic [WORD_SIZE-1:0]             i_data,
    output logic                             i_ready,
    output logic                             m_read,
    output logic [WORD_SIZE-1:0]             m_address,
    input  logic [WORD_SIZE*LINE_WORDS-1:0]  m_data,
    input  logic                             m_ack,
    output logic [WORD_SIZE-1:0]             num_hit,
    output logic [WORD_SIZE-1:0]             num_miss
);

    import instruction_cache_pkg::*;

    localparam int OFFSET_W = $clog2(LINE_WORDS);
    localparam int INDEX_W  = $clog2(NUM_LINES);
    localparam int TAG_W    = WORD_SIZE - OFFSET_W - INDEX_W;

    ic_state_e state_q, state_d;
    logic [WORD_SIZE-1:0] fill_addr_q;

    logic                 valid_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_q   [NUM_LINES];
    logic [WORD_SIZE-1:0] data_q  [NUM_LINES][LINE_WORDS];

    logic [OFFSET_W-1:0] req_offset;
    logic [INDEX_W-1:0]  req_index;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  fill_index;
    logic [TAG_W-1:0]    fill_tag;

    logic hit;
    logic miss;
    logic fill_done;

    assign req_offset = i_address[OFFSET_W-1:0];
    assign req_index  = i_address[OFFSET_W +: INDEX_W];
    assign req_tag    = i_address[WORD_SIZE-1 -: TAG_W];
    assign fill_index = fill_addr_q[OFFSET_W +: INDEX_W];
    assign fill_tag   = fill_addr_q[WORD_SIZE-1 -: TAG_W];

    // Lookups are only honoured in IDLE, so i_address changes during a fill are ignored.
    always_comb begin
        hit       = i_read && valid_q[req_index] && (tag_q[req_index] == req_tag)
                    && (state_q == IC_IDLE);
        miss      = i_read && !hit && (state_q == IC_IDLE);
        fill_done = (state_q == IC_FILL) && m_ack;
        i_ready   = !i_read || hit;
        i_data    = hit ? data_q[req_index][req_offset] : '0;
    end

    always_comb begin
        state_d   = state_q;
        m_read    = 1'b0;
        m_address = '0;
        case (state_q)
            IC_IDLE: begin
                if (miss) begin
                    state_d = IC_FILL;
                end
            end
            IC_FILL: begin
                m_read    = 1'b1;
                m_address = fill_addr_q;
                if (m_ack) begin
                    state_d = IC_IDLE;
                end
            end
            default: state_d = IC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IC_IDLE;
            fill_addr_q <= '0;
            for (int unsigned n = 0; n < NUM_LINES; n++) begin
                valid_q[n] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            if (miss) begin
                fill_addr_q <= {i_address[WORD_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end
            if (fill_done) begin
                valid_q[fill_index] <= 1'b1;
            end
        end
    end

    // fill_done needs state FILL, which reset forces to IDLE, so a coincident
    // m_ack and reset never writes these unreset arrays.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[fill_index] <= fill_tag;
            for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                data_q[fill_index][k] <= m_data[k*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    sat_counter #(.WIDTH(WORD_SIZE)) u_hit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (hit),
        .count   (num_hit)
    );

    sat_counter #(.WIDTH(WORD_SIZE)) u_miss_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (miss),
        .count   (num_miss)
    );

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: directed and random fetches checked
// against an address-arithmetic cache model and a behavioural memory.
module tb_instruction_cache;

    localparam int NL = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_read = 1'b0;
    logic [15:0] i_address = '0;
    logic [15:0] i_data;
    logic        i_ready;
    logic        m_read;
    logic [15:0] m_address;
    logic [63:0] m_data = '0;
    logic        m_ack = 1'b0;
    logic [15:0] num_hit;
    logic [15:0] num_miss;

    instruction_cache #(
        .WORD_SIZE  (16),
        .LINE_WORDS (4),
        .NUM_LINES  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_read    (i_read),
        .i_address (i_address),
        .i_data    (i_data),
        .i_ready   (i_ready),
        .m_read    (m_read),
        .m_address (m_address),
        .m_data    (m_data),
        .m_ack     (m_ack),
        .num_hit   (num_hit),
        .num_miss  (num_miss)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [15:0] sb_q[$];
    logic [15:0] fill_q[$];
    bit mem_en = 1'b1;
    bit mon_en = 1'b1;
    int fixed_n = 0;
    int last_n = 0;

    bit ref_valid [NL];
    int ref_tag   [NL];
    int ref_hit = 0;
    int ref_miss = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h4000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_lookup(input logic [15:0] a);
        int idx = (int'(a) / 4) % NL;
        return ref_valid[idx] && (ref_tag[idx] == int'(a) / 16);
    endfunction

    function automatic void ref_install(input logic [15:0] a);
        int idx = (int'(a) / 4) % NL;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = int'(a) / 16;
    endfunction

    function automatic void ref_reset();
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
        ref_hit  = 0;
        ref_miss = 0;
    endfunction

    function automatic void ref_count_hit();
        if (ref_hit < 65535) ref_hit++;
    endfunction

    function automatic void ref_count_miss();
        if (ref_miss < 65535) ref_miss++;
    endfunction

    task automatic check_counters(input string tag);
        chk({tag, "_num_hit"}, num_hit, ref_hit);
        chk({tag, "_num_miss"}, num_miss, ref_miss);
    endtask

    // Monitor: every cycle where the DUT presents a fetched word, pop and compare.
    initial begin
        logic [15:0] exp;
        forever begin
            @(negedge clk);
            if (mon_en && reset_n && i_read) begin
                if (i_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: got data %0h expected none at %0t", i_data, $time);
                    end else begin
                        exp = sb_q.pop_front();
                        chk("i_data", i_data, exp);
                    end
                end else begin
                    chk("i_data_stalled_zero", i_data, 0);
                end
            end
        end
    end

    // Memory model: answers each fill N cycles after m_read rises.
    initial begin
        int remaining = 0;
        bit busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_en) begin
                busy = 1'b0;
            end else begin
                if (m_ack) begin
                    m_ack = 1'b0;
                    busy  = 1'b0;
                end else if (!busy && m_read) begin
                    busy      = 1'b1;
                    remaining = (fixed_n > 0) ? fixed_n : int'($urandom_range(1, 4));
                    last_n    = remaining;
                    if (fill_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_fill: got m_address %0h expected no fill at %0t", m_address, $time);
                    end else begin
                        chk("m_address", m_address, fill_q.pop_front());
                    end
                end
                if (busy) begin
                    remaining--;
                    if (remaining == 0) begin
                        for (int k = 0; k < 4; k++) m_data[k*16 +: 16] = mem_word(m_address + 16'(k));
                        m_ack = 1'b1;
                    end
                end
            end
        end
    end

    task automatic fetch(input logic [15:0] a);
        bit h = ref_lookup(a);
        int stall;
        i_read    = 1'b1;
        i_address = a;
        sb_q.push_back(mem_word(a));
        if (!h) fill_q.push_back(a & 16'hFFFC);
        @(negedge clk);
        chk("first_ready", i_ready, h);
        if (h) begin
            chk("no_m_read_on_hit", m_read, 0);
            ref_count_hit();
        end else begin
            ref_count_miss();
            stall = 1;
            while (!i_ready && stall <= 20) begin
                @(negedge clk);
                if (!i_ready) stall++;
            end
            if (!i_ready) begin
                checks++;
                errors++;
                $display("FAIL fill_timeout: got no i_ready expected within 20 cycles at %0t", $time);
            end
            chk("stall_cycles", stall, last_n + 1);
            ref_install(a);
            ref_count_hit();
        end
        @(posedge clk);
        #1;
        i_read = 1'b0;
    endtask

    task automatic fetch_switch(input logic [15:0] a, input logic [15:0] b);
        int waited = 0;
        i_read    = 1'b1;
        i_address = a;
        sb_q.push_back(mem_word(b));
        fill_q.push_back(a & 16'hFFFC);
        @(negedge clk);
        chk("switch_first_ready", i_ready, 0);
        ref_count_miss();
        ref_install(a);
        @(posedge clk);
        #1;
        i_address = b;
        if (!ref_lookup(b)) begin
            fill_q.push_back(b & 16'hFFFC);
            ref_count_miss();
            ref_install(b);
        end
        ref_count_hit();
        do begin
            @(negedge clk);
            waited++;
        end while (!i_ready && waited < 40);
        if (!i_ready) begin
            checks++;
            errors++;
            $display("FAIL switch_timeout: got no i_ready expected within 40 cycles at %0t", $time);
        end
        @(posedge clk);
        #1;
        i_read = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        ref_reset();
        #12;
        chk("reset_m_read", m_read, 0);
        chk("reset_m_address", m_address, 0);
        chk("reset_i_ready", i_ready, 1);
        check_counters("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // First miss with a fixed two-cycle memory latency.
        fixed_n = 2;
        fetch(16'h0000);
        check_counters("first_fill");
        fixed_n = 0;
        for (int a = 1; a < 4; a++) fetch(16'(a));
        check_counters("seq_hits");

        // Same index, different tag evicts the line.
        fetch(16'h0010);
        fetch(16'h0000);
        check_counters("conflict");

        // Address change during FILL: line for 0x0005 still installed.
        fetch_switch(16'h0005, 16'h0020);
        fetch(16'h0005);
        check_counters("switch");

        for (int i = 0; i < 150; i++) fetch(16'($urandom_range(0, 127)));
        check_counters("random");

        // Reset mid-fill, then a stale m_ack that must be ignored.
        mem_en    = 1'b0;
        i_read    = 1'b1;
        i_address = 16'h0F00;
        @(posedge clk);
        #1;
        chk("fill_m_read", m_read, 1);
        chk("fill_m_address", m_address, 16'h0F00);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midfill_reset_m_read", m_read, 0);
        chk("midfill_reset_num_hit", num_hit, 0);
        chk("midfill_reset_num_miss", num_miss, 0);
        i_read = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_data  = {$urandom, $urandom};
        m_ack   = 1'b1;
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        chk("stale_ack_m_read", m_read, 0);
        ref_reset();
        check_counters("stale_ack");
        mem_en = 1'b1;
        fetch(16'h0F00);
        check_counters("after_reset");

        // Drive num_hit up to saturation with back-to-back hits.
        mon_en    = 1'b0;
        k         = 65534 - ref_hit;
        i_read    = 1'b1;
        i_address = 16'h0F00;
        repeat (k) @(posedge clk);
        #1;
        i_read = 1'b0;
        for (int i = 0; i < k; i++) ref_count_hit();
        chk("near_sat_num_hit", num_hit, 16'hFFFE);
        i_read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_read = 1'b0;
        for (int i = 0; i < 3; i++) ref_count_hit();
        check_counters("saturated");
        mon_en = 1'b1;

        chk("sb_drained", sb_q.size(), 0);
        chk("fills_drained", fill_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
